rf_dump_ctrl: RTL
=================

RF_DUMP_CTRL -- requirements
Module: rf_dump_ctrl

Interface
REQ-001 SHALL have parameter WD, default 32, meaning register data width.
REQ-002 SHALL have parameter SEL, default 5, meaning register index width (2^SEL registers).
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start_i  input  1  one-cycle request to begin an operation.
REQ-006 SHALL have port mode_i  input  1  0 = dump (read registers out), 1 = clear (write zero); sampled with start_i.
REQ-007 SHALL have port first_i  input  SEL  first register index; sampled with start_i.
REQ-008 SHALL have port last_i  input  SEL  last register index, inclusive; sampled with start_i.
REQ-009 SHALL have port rf_read_reg_o  output  SEL  drives the register-file read-select port.
REQ-010 SHALL have port rf_read_data_i  input  WD  asynchronous read data returned by the register file.
REQ-011 SHALL have port rf_we_o  output  1  register-file write enable.
REQ-012 SHALL have port rf_write_reg_o  output  SEL  register-file write-select.
REQ-013 SHALL have port rf_write_data_o  output  WD  register-file write data.
REQ-014 SHALL have port busy_o  output  1  high while an operation is in progress (CPU holds off register-file access).
REQ-015 SHALL have port done_o  output  1  one-cycle pulse at operation end.
REQ-016 SHALL have port dump_valid_o  output  1  dump beat valid.
REQ-017 SHALL have port dump_ready_i  input  1  downstream accepts beat.
REQ-018 SHALL have port dump_data_o  output  WD  captured register value.
REQ-019 SHALL have port dump_index_o  output  SEL  index of the register in dump_data_o.

Function
REQ-020 SHALL implement FSM states IDLE, READ, HOLD, CLEAR, DONE; busy_o = 1 in READ, HOLD, CLEAR.
REQ-021 IDLE: on start_i=1, latch mode_i/first_i/last_i, set idx=first_i; if first_i>last_i go to DONE (no reads, writes or beats); else mode 0 -> READ, mode 1 -> CLEAR.
REQ-022 READ (one cycle): rf_read_reg_o=idx; at clock edge capture rf_read_data_i into dump_data_o and idx into dump_index_o; go to HOLD.
REQ-023 HOLD: dump_valid_o=1; dump_data_o and dump_index_o stable while dump_ready_i=0.
REQ-024 HOLD with dump_ready_i=1: beat transferred; if idx==last go to DONE, else idx=idx+1 and go to READ (minimum 2 cycles per register).
REQ-025 CLEAR: rf_we_o=1, rf_write_reg_o=idx, rf_write_data_o=0 every cycle; if idx==last go to DONE, else idx=idx+1 (one register per cycle).
REQ-026 DONE: done_o=1 for exactly one cycle, busy_o=0; return to IDLE.
REQ-027 Outside CLEAR, rf_we_o=0 and rf_write_reg_o=0, rf_write_data_o=0; outside READ, rf_read_reg_o=0.
REQ-028 idx comparison with last SHALL occur before increment; last=2^SEL-1 SHALL terminate without idx wrap-around.
REQ-029 start_i SHALL be ignored in every state except IDLE; mode_i/first_i/last_i changes after latching SHALL have no effect.
REQ-030 first_i==last_i SHALL process exactly one register.
REQ-031 dump_valid_o SHALL be 0 in all states except HOLD; dump_ready_i outside HOLD SHALL be ignored.

Reset
REQ-032 reset=0 SHALL immediately (asynchronously) force state IDLE, idx=0 and all outputs to 0, including rf_we_o mid-CLEAR and dump_valid_o mid-HOLD.
REQ-033 After reset release, no operation SHALL begin until a new start_i.

Verification
REQ-034 Preload R1..R3 = 0x11,0x22,0x33; start_i mode 0 first 1 last 3, dump_ready_i=1 -> beats (1,0x11),(2,0x22),(3,0x33), done_o one pulse 6 cycles after READ entry.
REQ-035 Dump first 5 last 5, dump_ready_i low 4 cycles -> dump_valid_o held 4 cycles with data/index stable, single beat on ready, then done_o.
REQ-036 start_i mode 1 first 0 last 31 -> rf_we_o high 32 consecutive cycles, rf_write_reg_o 0..31, data 0, no wrap, done_o after index 31.
REQ-037 start_i first 7 last 3 -> no rf_we_o, no dump_valid_o, done_o next cycle, busy_o never high.
REQ-038 Assert reset low during CLEAR at index 10 -> rf_we_o, busy_o drop before next edge; after release second start_i while busy is ignored test: start_i during HOLD -> no restart, indices continue.

Source files
------------

// File: rtl/rf_dump_ctrl.sv
// Register-file dump/clear sequencer.
// Streams a register range out or zeroes it.
module rf_dump_ctrl #(
  parameter int WD  = 32,
  parameter int SEL = 5
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start_i,
  input  logic           mode_i,
  input  logic [SEL-1:0] first_i,
  input  logic [SEL-1:0] last_i,
  output logic [SEL-1:0] rf_read_reg_o,
  input  logic [WD-1:0]  rf_read_data_i,
  output logic           rf_we_o,
  output logic [SEL-1:0] rf_write_reg_o,
  output logic [WD-1:0]  rf_write_data_o,
  output logic           busy_o,
  output logic           done_o,
  output logic           dump_valid_o,
  input  logic           dump_ready_i,
  output logic [WD-1:0]  dump_data_o,
  output logic [SEL-1:0] dump_index_o
);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    HOLD,
    CLEAR,
    DONE
  } state_e;

  state_e         state_q;
  logic [SEL-1:0] idx_q;
  logic [SEL-1:0] last_q;
  logic [SEL-1:0] rd_reg_q;
  logic           we_q;
  logic [SEL-1:0] wr_reg_q;
  logic           busy_q;
  logic           done_q;
  logic           vld_q;
  logic [WD-1:0]  data_q;
  logic [SEL-1:0] dix_q;

  logic           at_last;
  logic [SEL-1:0] idx_d;

  // compare against last before stepping, so the top index never wraps
  always_comb begin
    at_last = (idx_q == last_q);
    idx_d   = idx_q + 1'b1;
  end

  // sequencer with every output registered off the next state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      last_q   <= '0;
      rd_reg_q <= '0;
      we_q     <= 1'b0;
      wr_reg_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      vld_q    <= 1'b0;
      data_q   <= '0;
      dix_q    <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start_i) begin
            idx_q  <= first_i;
            last_q <= last_i;
            if (first_i > last_i) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else if (!mode_i) begin
              state_q  <= READ;
              busy_q   <= 1'b1;
              rd_reg_q <= first_i;
            end else begin
              state_q  <= CLEAR;
              busy_q   <= 1'b1;
              we_q     <= 1'b1;
              wr_reg_q <= first_i;
            end
          end
        end
        READ: begin
          data_q   <= rf_read_data_i;
          dix_q    <= idx_q;
          vld_q    <= 1'b1;
          rd_reg_q <= '0;
          state_q  <= HOLD;
        end
        HOLD: begin
          if (dump_ready_i) begin
            vld_q <= 1'b0;
            if (at_last) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              idx_q    <= idx_d;
              rd_reg_q <= idx_d;
              state_q  <= READ;
            end
          end
        end
        CLEAR: begin
          if (at_last) begin
            state_q  <= DONE;
            we_q     <= 1'b0;
            wr_reg_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
          end else begin
            idx_q    <= idx_d;
            wr_reg_q <= idx_d;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign rf_read_reg_o   = rd_reg_q;
  assign rf_we_o         = we_q;
  assign rf_write_reg_o  = wr_reg_q;
  assign rf_write_data_o = '0;
  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign dump_valid_o    = vld_q;
  assign dump_data_o     = data_q;
  assign dump_index_o    = dix_q;

endmodule
